dma_desc_queue: RTL

Upstream command stage for top_module_DMA. It buffers transfer descriptors from the host/CPU side in a small FIFO. Each descriptor holds an origin address, a destination address and a byte count. The block issues descriptors to the DMA one at a time by driving OriginAddress/DestinationAddress/BytesQuantity, start and load, and retires each one on the DMA's INT. This removes per-transfer host polling and detects hung transfers.

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_desc_fifo.sv | 48 ++++
 rtl/dma_desc_queue.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA descriptor queue: default DMA port widths,
// the descriptor record and the issue-FSM state encoding.
package dma_pkg;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] orig;
    logic [ADDR_W-1:0] dest;
    logic [CNT_W-1:0]  cnt;
  } desc_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, FINISH} state_t;
endpackage

// File: rtl/dma_desc_fifo.sv
// Small synchronous descriptor FIFO with a separate level counter so that
// full/empty need no extra pointer wrap bit.
module dma_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 25
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic [W-1:0]                 wr_data_i,
  input  logic                         rd_en_i,
  output logic [W-1:0]                 rd_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] lvl_q;
  logic          wr, rd;

  assign full_o    = (lvl_q == LW'(DEPTH));
  assign empty_o   = (lvl_q == '0);
  assign level_o   = lvl_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr        = wr_en_i && !full_o;
  assign rd        = rd_en_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      lvl_q <= lvl_q + LW'(wr) - LW'(rd);
    end
  end

  // Storage carries no reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/dma_desc_queue.sv
// Descriptor queue in front of the DMA: buffers host descriptors, issues them
// one at a time, retires each on INT and aborts transfers that hang.
module dma_desc_queue #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = dma_pkg::ADDR_W,
  parameter int CNT_W       = dma_pkg::CNT_W,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [ADDR_W-1:0]           push_orig,
  input  logic [ADDR_W-1:0]           push_dest,
  input  logic [CNT_W-1:0]            push_cnt,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic [ADDR_W-1:0]           dma_origin,
  output logic [ADDR_W-1:0]           dma_dest,
  output logic [CNT_W-1:0]            dma_count,
  output logic                        dma_start,
  output logic                        dma_load,
  input  logic                        dma_int,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic                        zero_err,
  output logic                        timeout_err,
  input  logic                        err_clr
);
  import dma_pkg::*;

  localparam int TMR_W = $clog2(TIMEOUT_CYC+1);
  localparam int DW    = 2*ADDR_W + CNT_W;

  typedef struct packed {
    logic [ADDR_W-1:0] orig;
    logic [ADDR_W-1:0] dest;
    logic [CNT_W-1:0]  cnt;
  } qdesc_t;

  qdesc_t           push_desc, head_desc, issued_q, issued_d;
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             ovf_q, ovf_d, zero_q, zero_d, tmo_q, tmo_d;
  logic             push_ok, pop, tmo_hit;

  assign push_desc = '{orig: push_orig, dest: push_dest, cnt: push_cnt};
  assign push_ok   = push && !full && (push_cnt != '0);

  dma_desc_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en_i   (push_ok),
    .wr_data_i (push_desc),
    .rd_en_i   (pop),
    .rd_data_o (head_desc),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level)
  );

  // Fields are captured on entry to ISSUE so they lead dma_start by a cycle.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    issued_d = issued_q;
    pop      = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          issued_d = head_desc;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        pop     = 1'b1;
        tmr_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (dma_int) begin
          state_d = FINISH;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC-1)) begin
          tmo_hit = 1'b1;
          state_d = FINISH;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      FINISH: begin
        tmr_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: a new set event wins over a same-cycle clear.
  always_comb begin
    ovf_d  = err_clr ? 1'b0 : ovf_q;
    zero_d = err_clr ? 1'b0 : zero_q;
    tmo_d  = err_clr ? 1'b0 : tmo_q;
    if (push && full)           ovf_d  = 1'b1;
    if (push && push_cnt == '0) zero_d = 1'b1;
    if (tmo_hit)                tmo_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      issued_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      issued_q <= issued_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      tmo_q    <= tmo_d;
    end
  end

  assign dma_origin  = issued_q.orig;
  assign dma_dest    = issued_q.dest;
  assign dma_count   = issued_q.cnt;
  assign dma_start   = (state_q == RUN);
  assign dma_load    = (state_q == FINISH);
  assign done        = (state_q == FINISH);
  assign busy        = (state_q != IDLE);
  assign overflow    = ovf_q;
  assign zero_err    = zero_q;
  assign timeout_err = tmo_q;
endmodule
